uart_rx: RTL and testbench

- 8N1 UART receiver, the receive-side counterpart of the team's UART transmitter. Line format: idle high, one start bit (0), 8 data bits LSB first, one stop bit (1).
- Synchronises the asynchronous serial input and times each bit with an internal per-bit counter. Samples each bit at its centre.
- Presents each received byte with a one-cycle valid pulse, and flags framing errors.
- Sits beside the transmitter in the UART top level, driven by the same clk/reset.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and default bit timing.
// Used by both the receiver and the transmitter so the encodings stay in step.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } uart_state_t;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: serial line in, byte/valid/error/busy out.
// No backpressure: the consumer must catch the one-cycle rx_valid pulse.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_error;
    logic                 rx_busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_error,
        output rx_busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_error,
        input  rx_busy
    );
endinterface

// File: rtl/uart_sync.sv
// N-flop synchroniser for an asynchronous level input; resets to 1 (idle-high lines).
// Latency SYNC_STAGES cycles; no backpressure.
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampled bits, one-cycle rx_valid / frame_error pulses.
// rx_valid follows mid-stop-bit by SYNC_STAGES+1 cycles; no backpressure (missed pulses lose the byte).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);

    uart_state_t          r_state, w_state_nxt;
    logic [CW-1:0]        r_clk_cnt, w_cnt_nxt;
    logic [2:0]           r_bit_idx, w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_ferr, w_ferr_nxt;
    logic                 r_rx_s_prev;
    logic                 w_rx_s;
    logic                 w_fall;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.rx),
        .o_q   (w_rx_s)
    );

    assign w_fall = ~w_rx_s & r_rx_s_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
            r_rx_s_prev <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_clk_cnt   <= w_cnt_nxt;
            r_bit_idx   <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_ferr      <= w_ferr_nxt;
            r_rx_s_prev <= w_rx_s;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_clk_cnt;
        w_idx_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = START;
                end
            end

            // A line that is high again at mid start bit was only a glitch.
            START: begin
                if (r_clk_cnt == HALF) begin
                    if (!w_rx_s) begin
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_state_nxt = DATA;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_clk_cnt + CW'(1);
                end
            end

            DATA: begin
                if (r_clk_cnt == FULL) begin
                    w_shift_nxt[r_bit_idx] = w_rx_s;
                    w_cnt_nxt              = '0;
                    w_idx_nxt              = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    w_cnt_nxt = r_clk_cnt + CW'(1);
                end
            end

            // Leaving at mid stop bit gives half a bit of slack before the next start edge.
            STOP: begin
                if (r_clk_cnt == FULL) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = BREAK_WAIT;
                    end
                end else begin
                    w_cnt_nxt = r_clk_cnt + CW'(1);
                end
            end

            BREAK_WAIT: begin
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.rx_data     = r_data;
    assign bus.rx_valid    = r_valid;
    assign bus.frame_error = r_ferr;
    assign bus.rx_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: normal, back-to-back, glitch,
// break, mid-frame reset and +/-3% baud frames, checked against hand-computed values.
module tb_uart_rx;

    localparam int CPB    = 16;
    localparam int CLK_NS = 10;
    localparam int BIT_NS = CPB * CLK_NS;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   valid_cnt;
    int   ferr_cnt;
    int   both_cnt;
    logic [7:0] data_q[$];

    uart_rx_if u_if ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #(CLK_NS / 2) clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (u_if.rx_valid) begin
                valid_cnt = valid_cnt + 1;
                data_q.push_back(u_if.rx_data);
            end
            if (u_if.frame_error) ferr_cnt = ferr_cnt + 1;
            if (u_if.rx_valid && u_if.frame_error) both_cnt = both_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (i < data_q.size()) return {24'h0, data_q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic send_byte(input logic [7:0] d, input int bit_ns, input logic stop_val);
        u_if.rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            u_if.rx = d[i];
            #(bit_ns);
        end
        u_if.rx = stop_val;
        #(bit_ns);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        valid_cnt = 0;
        ferr_cnt  = 0;
        both_cnt  = 0;
        u_if.rx   = 1'b1;
        reset     = 1'b1;

        #1;
        check("reset_data",  {24'h0, u_if.rx_data}, 32'h00);
        check("reset_valid", {31'h0, u_if.rx_valid}, 32'h0);
        check("reset_ferr",  {31'h0, u_if.frame_error}, 32'h0);
        check("reset_busy",  {31'h0, u_if.rx_busy}, 32'h0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Single frame after a long idle.
        idle_cycles(100);
        check("idle_busy", {31'h0, u_if.rx_busy}, 32'h0);
        send_byte(8'hA5, BIT_NS, 1'b1);
        idle_cycles(20);
        check("a5_count", valid_cnt, 1);
        check("a5_data",  q_at(0), 32'hA5);
        check("a5_hold",  {24'h0, u_if.rx_data}, 32'hA5);
        check("a5_ferr",  ferr_cnt, 0);

        // Back-to-back frames, no idle between stop and next start.
        send_byte(8'h00, BIT_NS, 1'b1);
        send_byte(8'hFF, BIT_NS, 1'b1);
        send_byte(8'h3C, BIT_NS, 1'b1);
        idle_cycles(20);
        check("b2b_count", valid_cnt, 4);
        check("b2b_d0", q_at(1), 32'h00);
        check("b2b_d1", q_at(2), 32'hFF);
        check("b2b_d2", q_at(3), 32'h3C);
        check("b2b_ferr", ferr_cnt, 0);

        // Four-cycle low glitch must be rejected at mid start bit.
        @(negedge clk);
        u_if.rx = 1'b0;
        #(4 * CLK_NS);
        u_if.rx = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!u_if.rx_busy) break;
        end
        check("glitch_busy",  {31'h0, u_if.rx_busy}, 32'h0);
        idle_cycles(20);
        check("glitch_valid", valid_cnt, 4);
        check("glitch_ferr",  ferr_cnt, 0);

        // Low stop bit followed by a held-low line: one frame_error, data kept.
        send_byte(8'h55, BIT_NS, 1'b0);
        #(50 * CLK_NS);
        u_if.rx = 1'b1;
        idle_cycles(20);
        check("brk_ferr",  ferr_cnt, 1);
        check("brk_valid", valid_cnt, 4);
        check("brk_data",  {24'h0, u_if.rx_data}, 32'h3C);
        check("brk_busy",  {31'h0, u_if.rx_busy}, 32'h0);
        send_byte(8'h81, BIT_NS, 1'b1);
        idle_cycles(20);
        check("post_brk_count", valid_cnt, 5);
        check("post_brk_data",  q_at(4), 32'h81);

        // Reset in the middle of data bit 4 of 0x96.
        u_if.rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            u_if.rx = 1'((8'h96 >> i) & 8'h01);
            #(BIT_NS);
        end
        u_if.rx = 1'b1;
        #(BIT_NS / 2 + 3);
        check("pre_rst_busy", {31'h0, u_if.rx_busy}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_data",  {24'h0, u_if.rx_data}, 32'h00);
        check("rst_valid", {31'h0, u_if.rx_valid}, 32'h0);
        check("rst_ferr",  {31'h0, u_if.frame_error}, 32'h0);
        check("rst_busy",  {31'h0, u_if.rx_busy}, 32'h0);
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        idle_cycles(40);
        check("rst_no_pulse", valid_cnt, 5);
        send_byte(8'h69, BIT_NS, 1'b1);
        idle_cycles(20);
        check("post_rst_count", valid_cnt, 6);
        check("post_rst_data",  q_at(5), 32'h69);

        // Transmitter running 3% fast, then 3% slow.
        send_byte(8'hC3, BIT_NS * 97 / 100, 1'b1);
        idle_cycles(20);
        send_byte(8'hC3, BIT_NS * 103 / 100, 1'b1);
        idle_cycles(20);
        check("baud_count", valid_cnt, 8);
        check("baud_fast",  q_at(6), 32'hC3);
        check("baud_slow",  q_at(7), 32'hC3);
        check("final_ferr", ferr_cnt, 1);
        check("no_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
